// File: rtl/mcpu_ifetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_ifetch_if
//  Description : Bus bundle for the MCPU instruction fetch unit. It carries the
//                redirect request, both instruction ROM ports, the decoder
//                byte stream and the stall statistic.
//                master = fetch unit, slave = ROM/decoder/branch side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mcpu_ifetch_if #(
    parameter int IROM_ADDR_BITS = 14
);
    logic                      redirect;
    logic [IROM_ADDR_BITS-1:0] redirect_addr;
    logic [IROM_ADDR_BITS-1:0] irom_addr0;
    logic [IROM_ADDR_BITS-1:0] irom_addr1;
    logic [7:0]                irom_out0;
    logic [7:0]                irom_out1;
    logic                      out_valid;
    logic [7:0]                out_data;
    logic [IROM_ADDR_BITS-1:0] out_addr;
    logic                      out_ready;
    logic [15:0]               stall_cnt;

    modport master (
        input  redirect, redirect_addr, irom_out0, irom_out1, out_ready,
        output irom_addr0, irom_addr1, out_valid, out_data, out_addr, stall_cnt
    );

    modport slave (
        output redirect, redirect_addr, irom_out0, irom_out1, out_ready,
        input  irom_addr0, irom_addr1, out_valid, out_data, out_addr, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mcpu_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_ifetch
//  Description : Instruction fetch controller with prefetch queue. Reads two
//                consecutive ROM bytes per cycle from a dual-port
//                combinational-read ROM, buffers them in a small FIFO and
//                streams them to the decoder over valid/ready. A redirect
//                flushes the queue and restarts fetch at a new address.
//                Optional macro MCPU_IFETCH_STATS_EN enables the saturating
//                consumer-starved cycle counter on stall_cnt; without it the
//                port is tied to zero.
//                FIFO_DEPTH must be a power of 2 and at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcpu_ifetch #(
    parameter int                        IROM_ADDR_BITS = 14,
    parameter int                        FIFO_DEPTH     = 4,
    parameter logic [IROM_ADDR_BITS-1:0] RESET_ADDR     = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    mcpu_ifetch_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [IROM_ADDR_BITS-1:0] fetch_pc;
    logic [IROM_ADDR_BITS-1:0] fetch_pc_p1;
    logic [7:0]                q_data [FIFO_DEPTH];
    logic [IROM_ADDR_BITS-1:0] q_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          free;
    logic [1:0]                push_n;
    logic                      pop;
    logic                      valid;

    assign fetch_pc_p1 = fetch_pc + IROM_ADDR_BITS'(1);
    assign valid       = (count != '0);
    assign pop         = valid && bus.out_ready;

    // ROM addresses come straight from the fetch_pc register: no input-to-output path
    assign bus.irom_addr0 = fetch_pc;
    assign bus.irom_addr1 = fetch_pc_p1;

    assign bus.out_valid = valid;
    assign bus.out_data  = q_data[rd_ptr];
    assign bus.out_addr  = q_addr[rd_ptr];

    // Fetch width from free space at the start of the cycle; a same-cycle pop frees nothing yet
    always_comb begin
        free   = DEPTH_CNT - count;
        push_n = 2'd0;
        if (!bus.redirect) begin
            if (free >= CNT_W'(2)) begin
                push_n = 2'd2;
            end else if (free == CNT_W'(1)) begin
                push_n = 2'd1;
            end
        end
    end

    // Queue storage, pointers, occupancy and fetch address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_ADDR;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
        end else if (bus.redirect) begin
            // Flush: any pop accepted this cycle is discarded along with the queue
            fetch_pc <= bus.redirect_addr;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push_n != 2'd0) begin
                q_data[wr_ptr] <= bus.irom_out0;
                q_addr[wr_ptr] <= fetch_pc;
            end
            if (push_n == 2'd2) begin
                q_data[wr_ptr + PTR_W'(1)] <= bus.irom_out1;
                q_addr[wr_ptr + PTR_W'(1)] <= fetch_pc_p1;
            end
            wr_ptr   <= wr_ptr + PTR_W'(push_n);
            fetch_pc <= fetch_pc + IROM_ADDR_BITS'(push_n);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_n) - CNT_W'(pop);
        end
    end

`ifdef MCPU_IFETCH_STATS_EN
    logic [15:0] stall_q;

    // Count cycles where the decoder is ready but no byte is available, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.out_ready && !valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcpu_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcpu_ifetch
//  Description : Self-checking bench for mcpu_ifetch. A random ROM image is
//                served combinationally; a queue-based reference model tracks
//                the expected byte stream, fetch address and stall count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_ifetch;

    localparam int AW    = 14;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    logic clk;
    logic rst_n;
    logic [7:0] rom [1 << AW];

    int n_pass;
    int n_checks;

    ent_t          mq [$];
    logic [AW-1:0] mpc;
    int            mstall;

    mcpu_ifetch_if #(.IROM_ADDR_BITS(AW)) bus ();

    mcpu_ifetch #(
        .IROM_ADDR_BITS (AW),
        .FIFO_DEPTH     (DEPTH),
        .RESET_ADDR     ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.irom_out0 = rom[bus.irom_addr0];
    assign bus.irom_out1 = rom[bus.irom_addr1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc    = '0;
        mstall = 0;
    endtask

    task automatic check_outputs();
        logic [AW-1:0] nxt;
        nxt = mpc + AW'(1);
        check("irom_addr0", 32'(bus.irom_addr0), 32'(mpc));
        check("irom_addr1", 32'(bus.irom_addr1), 32'(nxt));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_data", 32'(bus.out_data), 32'(mq[0].d));
            check("out_addr", 32'(bus.out_addr), 32'(mq[0].a));
        end
`ifdef MCPU_IFETCH_STATS_EN
        check("stall_cnt", 32'(bus.stall_cnt), 32'(mstall));
`else
        check("stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check at negedge
    task automatic step(input logic rd, input logic [AW-1:0] ra, input logic rdy);
        int   free;
        int   n;
        logic mvalid;
        ent_t e;
        bus.redirect      = rd;
        bus.redirect_addr = ra;
        bus.out_ready     = rdy;
        @(posedge clk);
        mvalid = (mq.size() != 0);
        if (rdy && !mvalid && mstall < 65535) mstall++;
        if (rd) begin
            mq.delete();
            mpc = ra;
        end else begin
            free = DEPTH - mq.size();
            if (mvalid && rdy) void'(mq.pop_front());
            n = (free >= 2) ? 2 : free;
            for (int k = 0; k < n; k++) begin
                e.a = mpc;
                e.d = rom[mpc];
                mq.push_back(e);
                mpc = mpc + AW'(1);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset asserted between edges, released on a falling edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_addr", 32'(bus.out_addr), 32'd0);
        check("rst_pc", 32'(bus.irom_addr0), 32'd0);
        check("rst_stall", 32'(bus.stall_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
        rst_n             = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.out_ready     = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Streaming from reset with the decoder always ready
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Decoder stalled: queue fills, fetch address freezes at 4
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        check("full_pc", 32'(bus.irom_addr0), 32'd4);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Build occupancy 3, one-slot refill, then redirect to 0x0123
        do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("occ3_pc", 32'(bus.irom_addr0), 32'd5);
        step(1'b1, AW'(14'h0123), 1'b1);
        check("redir_gap", 32'(bus.out_valid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("redir_first", 32'(bus.out_addr), 32'h0123);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Address wrap-around at the top of the ROM
        step(1'b1, AW'(14'h3FFE), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Randomised traffic with occasional redirects, some near the wrap point
        for (int i = 0; i < 2000; i++) begin
            logic          rd;
            logic [AW-1:0] ra;
            rd = ($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + $urandom_range(0, 3))
                                             : AW'($urandom);
            step(rd, ra, ($urandom_range(0, 2) != 0));
            if (i == 1000) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
